rtc_alarm_core: RTL

Parametrised real-time-counter core, the next generation of the APB4 RTC counter datapath. It has a programmable prescaler, a loadable free-running counter of configurable width, ALARM_NUM independent compare channels and an overflow flag. All interrupt flags are sticky and are cleared individually. It sits below the APB4 register shell, which drives the configuration inputs and reads the counter and flags. Everything runs on the RTC clock domain.

---
 rtl/rtc_alarm_core.sv | 115 +++++++++++
 1 files changed

// File: rtl/rtc_alarm_core.sv
// Real-time counter core: prescaled loadable counter with ALARM_NUM sticky compare flags and an overflow flag.
// Optional build macro RTC_TICK_IRQ_EN adds a sticky tick flag (tick_irq_o / tick_clr_i).
module rtc_alarm_ch #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  input  logic         en_i,
  input  logic [W-1:0] nxt_i,
  input  logic [W-1:0] val_i,
  input  logic         clr_i,
  output logic         flag_o
);
  logic flag_q, flag_d;

  // A set on the same edge as a clear wins.
  always_comb flag_d = (inc_i & en_i & (nxt_i == val_i)) | (flag_q & ~clr_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) flag_q <= 1'b0;
    else          flag_q <= flag_d;
  end

  assign flag_o = flag_q;
endmodule

module rtc_alarm_core #(
  parameter int CNT_WIDTH = 32,
  parameter int PSC_WIDTH = 20,
  parameter int ALARM_NUM = 4
) (
  input  logic                           rtc_clk_i,
  input  logic                           rtc_rst_n_i,
  input  logic                           en_i,
  input  logic [PSC_WIDTH-1:0]           psc_i,
  input  logic                           load_i,
  input  logic [CNT_WIDTH-1:0]           load_val_i,
  input  logic [ALARM_NUM-1:0]           alrm_en_i,
  input  logic [ALARM_NUM*CNT_WIDTH-1:0] alrm_val_i,
  input  logic [ALARM_NUM:0]             irq_clr_i,
`ifdef RTC_TICK_IRQ_EN
  input  logic                           tick_clr_i,
  output logic                           tick_irq_o,
`endif
  output logic [CNT_WIDTH-1:0]           cnt_o,
  output logic                           tick_o,
  output logic [ALARM_NUM-1:0]           alrm_irq_o,
  output logic                           ovf_irq_o,
  output logic                           irq_o
);
  logic [PSC_WIDTH-1:0] psc_q, psc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 tick_q, ovf_q, ovf_d, inc;

  assign cnt_inc = cnt_q + CNT_WIDTH'(1);
  // Load overrides the increment entirely: no tick, no compare, no overflow.
  assign inc     = en_i & ~load_i & (psc_q == psc_i);

  always_comb begin
    psc_d = psc_q;
    cnt_d = cnt_q;
    if (load_i) begin
      psc_d = '0;
      cnt_d = load_val_i;
    end else if (en_i) begin
      psc_d = (psc_q == psc_i) ? '0 : psc_q + PSC_WIDTH'(1);
      if (inc) cnt_d = cnt_inc;
    end
    ovf_d = (inc & (&cnt_q)) | (ovf_q & ~irq_clr_i[ALARM_NUM]);
  end

  always_ff @(posedge rtc_clk_i) begin
    if (!rtc_rst_n_i) begin
      psc_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      cnt_q  <= cnt_d;
      tick_q <= inc;
      ovf_q  <= ovf_d;
    end
  end

  for (genvar k = 0; k < ALARM_NUM; k++) begin : g_ch
    rtc_alarm_ch #(.W(CNT_WIDTH)) u_ch (
      .clk_i   (rtc_clk_i),
      .rst_n_i (rtc_rst_n_i),
      .inc_i   (inc),
      .en_i    (alrm_en_i[k]),
      .nxt_i   (cnt_inc),
      .val_i   (alrm_val_i[k*CNT_WIDTH +: CNT_WIDTH]),
      .clr_i   (irq_clr_i[k]),
      .flag_o  (alrm_irq_o[k])
    );
  end

`ifdef RTC_TICK_IRQ_EN
  logic tirq_q;
  always_ff @(posedge rtc_clk_i) begin
    if (!rtc_rst_n_i) tirq_q <= 1'b0;
    else              tirq_q <= inc | (tirq_q & ~tick_clr_i);
  end
  assign tick_irq_o = tirq_q;
  assign irq_o      = (|alrm_irq_o) | ovf_q | tirq_q;
`else
  assign irq_o      = (|alrm_irq_o) | ovf_q;
`endif

  assign cnt_o     = cnt_q;
  assign tick_o    = tick_q;
  assign ovf_irq_o = ovf_q;
endmodule
